// File: rtl/nrf_spi_master.sv
// Mode-0 SPI master PHY for the nRF24L01: one byte per start/busy handshake, MSB first.
// Optional SPI_CSN_HOLD_EN keeps CSN low across bytes while csn_hold_i is set.
module nrf_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int CSN_SETUP = 2,
  parameter int CSN_IDLE  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_start_i,
  input  logic [7:0] spi_tx_data_i,
  output logic [7:0] spi_rx_data_o,
  output logic       busy_o,
  output logic       done_o,
  input  logic       csn_hold_i,
  output logic       spi_sck_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       spi_csn_o
);

  localparam int HP_W    = $clog2(CLK_DIV) + 1;
  localparam int TMR_MAX = (CSN_SETUP > CSN_IDLE) ? CSN_SETUP : CSN_IDLE;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_GAP,
    ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [3:0]        half_q, half_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [6:0]        tx_sh_q, tx_sh_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              csn_q, csn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifndef SPI_CSN_HOLD_EN
  logic unused_csn_hold;
  assign unused_csn_hold = csn_hold_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hp_q      <= '0;
      half_q    <= '0;
      tmr_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= 8'h00;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      half_q    <= half_d;
      tmr_q     <= tmr_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    half_d    = half_q;
    tmr_d     = tmr_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (spi_start_i) begin
          state_d = ST_SETUP;
          tx_sh_d = spi_tx_data_i[6:0];
          mosi_d  = spi_tx_data_i[7];
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          tmr_d   = TMR_W'(CSN_SETUP - 1);
        end
      end

      ST_SETUP: begin
        if (tmr_q == '0) begin
          state_d = ST_XFER;
          hp_d    = HP_W'(CLK_DIV - 1);
          half_d  = 4'd0;
          sck_d   = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_XFER: begin
        if (hp_q != '0) begin
          hp_d = hp_q - 1'b1;
        end else if (half_q == 4'd15) begin
          sck_d     = 1'b0;
          mosi_d    = 1'b0;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
`ifdef SPI_CSN_HOLD_EN
          if (csn_hold_i) begin
            state_d = ST_HOLD;
            busy_d  = 1'b0;
          end else
`endif
          begin
            state_d = ST_GAP;
            csn_d   = 1'b1;
            tmr_d   = TMR_W'(CSN_IDLE - 1);
          end
        end else begin
          // even half-period ends with a rising SCK edge, odd with a falling one
          hp_d   = HP_W'(CLK_DIV - 1);
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], spi_miso_i};
          end else begin
            sck_d   = 1'b0;
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
          end
        end
      end

      ST_GAP: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_HOLD: begin
        // CSN is already low, so the next byte skips the setup delay
        if (spi_start_i) begin
          state_d = ST_XFER;
          tx_sh_d = spi_tx_data_i[6:0];
          mosi_d  = spi_tx_data_i[7];
          busy_d  = 1'b1;
          hp_d    = HP_W'(CLK_DIV - 1);
          half_d  = 4'd0;
        end else if (!csn_hold_i) begin
          state_d = ST_GAP;
          csn_d   = 1'b1;
          busy_d  = 1'b1;
          tmr_d   = TMR_W'(CSN_IDLE - 1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign spi_rx_data_o = rx_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign spi_sck_o     = sck_q;
  assign spi_mosi_o    = mosi_q;
  assign spi_csn_o     = csn_q;

endmodule
